// File: rtl/rll_key_loader.sv
// rll_key_loader: fetches the unlock key for an RLL-locked core from a
// request/acknowledge key store, verifies it against the stored XOR
// checksum and only then presents it to the core. The key outputs stay
// zero unless a verified key is being applied.
module rll_key_loader #(
  parameter int KEY_W   = 32,
  parameter int WORD_W  = 8,
  parameter int TIMEOUT = 15,
  localparam int NWORDS = KEY_W / WORD_W,
  localparam int AW     = $clog2(NWORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  output logic              rd_req,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_ack,
  input  logic [WORD_W-1:0] rd_data,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic              start_q;
  logic              in_load;
  logic [AW-1:0]     addr;
  logic [KEY_W-1:0]  shadow;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] csum;
  logic [7:0]        tcnt;

  assign in_load = (state == S_REQ) || (state == S_GAP) || (state == S_CHECK);
  assign rd_addr = addr;

  // Next-state decision; clear overrides everything, ack beats timeout.
  always_comb begin
    nxt = state;
    if (clear) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_READY, S_ERROR: begin
          if (start_q) nxt = S_REQ;
        end
        S_REQ: begin
          if (rd_ack) nxt = S_GAP;
          else if (tcnt == 8'(TIMEOUT - 1)) nxt = S_ERROR;
        end
        S_GAP: begin
          nxt = (addr < AW'(NWORDS)) ? S_REQ : S_CHECK;
        end
        S_CHECK: begin
          nxt = (acc == csum) ? S_READY : S_ERROR;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State register plus a registered start; starts seen mid-load are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= nxt;
      start_q <= start && !clear && !in_load;
    end
  end

  // Shadow key, checksum accumulator, address and per-word timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      shadow <= '0;
      acc    <= '0;
      csum   <= '0;
      tcnt   <= '0;
    end else if (clear) begin
      shadow <= '0;
      acc    <= '0;
      csum   <= '0;
      tcnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_READY, S_ERROR: begin
          if (start_q) begin
            addr   <= '0;
            shadow <= '0;
            acc    <= '0;
            csum   <= '0;
            tcnt   <= '0;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            tcnt <= '0;
            if (addr < AW'(NWORDS)) begin
              for (int k = 0; k < NWORDS; k++) begin
                if (addr == AW'(k)) shadow[k*WORD_W +: WORD_W] <= rd_data;
              end
              acc <= acc ^ rd_data;
            end else begin
              csum <= rd_data;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_GAP: begin
          if (addr < AW'(NWORDS)) addr <= addr + AW'(1);
        end
        S_CHECK: begin
          if (acc != csum) shadow <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req    <= 1'b0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      key       <= '0;
    end else begin
      rd_req    <= (nxt == S_REQ);
      busy      <= (nxt == S_REQ) || (nxt == S_GAP) || (nxt == S_CHECK);
      key_valid <= (nxt == S_READY);
      err       <= (nxt == S_ERROR);
      if (nxt == S_READY) begin
        if (state != S_READY) key <= shadow;
      end else begin
        key <= '0;
      end
    end
  end

endmodule

// File: doc/rll_key_loader.md
# rll_key_loader

Sequencer that fetches the 32-bit unlock key for an RLL-locked combinational core from an external key store over a request/acknowledge read port, verifies it against a stored XOR checksum, and drives the core's key inputs. It sits between the key store and the locked core. The locked core's outputs are only qualified after a verified key has been applied. Key bits are zero outside the READY state, so an unverified or partial key never reaches the core.

## Interface
- KEY_W, 32: key width; bit i drives core key input keyIn_0_i.
- WORD_W, 8: key-store word width; KEY_W is a multiple of WORD_W.
- TIMEOUT, 15: maximum REQ cycles without rd_ack before abort, range 1..255.
- Derived: NWORDS = KEY_W/WORD_W (4). AW = clog2(NWORDS+1) (3).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  load request, single-cycle pulse.
- clear  in  1  zeroize key and return to IDLE.
- rd_req  out  1  key-store read request.
- rd_addr  out  AW  word address, valid while rd_req=1.
- rd_ack  in  1  read acknowledge; rd_data valid in the same cycle.
- rd_data  in  WORD_W  key-store read data.
- key  out  KEY_W  key to the locked core.
- key_valid  out  1  key verified and applied; also gates the core's outputs.
- busy  out  1  load in progress (REQ, GAP or CHECK).
- err  out  1  last load failed (checksum or timeout); sticky until next start, clear or reset.

## Operation
- States: IDLE, REQ, GAP, CHECK, READY, ERROR.
- Address map:
  - Words 0..NWORDS-1 hold the key, little-endian: word k loads shadow[k*WORD_W +: WORD_W].
  - Word NWORDS holds the checksum, equal to the XOR of all key words.
- IDLE/READY/ERROR + start → REQ at address 0.
  - Entering REQ: shadow, checksum accumulator and timeout counter are cleared.
  - Also: key=0, key_valid=0, err=0.
- REQ:
  - rd_req=1; rd_addr holds the current address.
  - If rd_ack=1: capture rd_data and go to GAP. Key words are stored into shadow and XORed into the accumulator; the checksum word is compared.
  - If rd_ack=0: the timeout counter increments. When TIMEOUT cycles without ack complete → ERROR.
  - Ack in the same cycle the timeout would expire: ack wins.
- GAP:
  - rd_req=0 for exactly one cycle.
  - If address < NWORDS: increment address → REQ.
  - Otherwise → CHECK.
- CHECK:
  - Accumulator equals checksum word: key ← shadow, key_valid=1 → READY.
  - Mismatch: shadow zeroed, err=1 → ERROR.
- READY: key and key_valid are held.
- ERROR: key=0, key_valid=0, err=1.
- start while busy=1 is ignored.
- clear, in any state, at the next edge:
  - key=0, shadow=0, key_valid=0, err=0 → IDLE.
  - clear has priority over start and over rd_ack.
- rd_ack outside REQ is ignored. rd_data is never sampled outside REQ.
- A reset or clear mid-load abandons the transaction; rd_req drops immediately, with asynchronous effect for rst_n.

## Timing
- Reset values:
  - State IDLE.
  - rd_req=0, rd_addr=0, key=0, key_valid=0, busy=0, err=0.
  - Internal shadow, accumulator and counter are 0.
- All outputs are registered; no combinational path from input to output.
- With rd_ack tied high, key_valid rises 12 edges after the edge that samples start:
  - 5 words × (REQ+GAP), then CHECK, then READY.
  - In general: 2·(NWORDS+1)+2 edges.
- Each additional wait cycle in REQ adds exactly one edge.
- rd_addr and rd_req change only at edges entering or leaving REQ. rd_addr is stable for the full request.
- Timeout: with no ack, ERROR is entered at the edge ending the TIMEOUT-th REQ cycle of that word. err is visible in the following cycle.
- key changes only on entry to READY (to shadow) or on leaving READY (to 0). It never holds a partial value.

## Test plan
- Nominal load:
  - Stimulus: store words 0x11,0x22,0x33,0x44, checksum 0x44^0x33^0x22^0x11=0x44; rd_ack tied high; start pulse.
  - Required: key=0x44332211 and key_valid=1 exactly 12 edges after start; err=0; rd_req low for one cycle between requests.
- Wait states:
  - Stimulus: rd_ack delayed 3 cycles on word 2.
  - Required: key_valid at edge 15; rd_addr held at 2 throughout the wait.
- Bad checksum:
  - Stimulus: checksum word 0x45.
  - Required: err=1, key=0, key_valid=0 after CHECK; a subsequent start with a correct store reaches READY with err=0.
- Timeout:
  - Stimulus: TIMEOUT=4; no ack on word 1.
  - Required: ERROR after 4 REQ cycles; rd_req=0 afterwards.
  - Stimulus: ack in cycle 4.
  - Required: proceeds normally.
- Clear and reset:
  - Stimulus: clear asserted in READY.
  - Required: key=0, key_valid=0 next cycle.
  - Stimulus: rst_n low mid-REQ.
  - Required: rd_req and all outputs drop asynchronously; state IDLE.
  - Stimulus: start and clear asserted together.
  - Required: IDLE.
- Reload and ignored start:
  - Stimulus: start while READY with a new key.
  - Required: key=0 during reload, new key applied at edge 12.
  - Stimulus: start during busy.
  - Required: ignored, with no address restart.
